// File: rtl/fdd_track_cache.sv
// Floppy track cache: writes back dirty sectors of the cached track, then loads the
// requested track block by block over the SD block interface while stalling the CPU.
module fdd_track_cache #(
    parameter int unsigned SECTORS = 13,
    parameter int unsigned DRIVES  = 2,
    parameter int unsigned TRACK_W = 6,
    localparam int unsigned DRV_W  = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [DRV_W-1:0]           drive_sel,
    input  logic [DRIVES*TRACK_W-1:0]  track,
    input  logic [DRIVES-1:0]          img_mounted,
    input  logic                       img_size_nz,
    input  logic                       img_readonly,
    input  logic                       fd_write_disk,
    input  logic [12:0]                fd_track_addr,
    output logic [31:0]                sd_lba,
    output logic [DRIVES-1:0]          sd_rd,
    output logic [DRIVES-1:0]          sd_wr,
    input  logic [DRIVES-1:0]          sd_ack,
    output logic [3:0]                 buf_sec,
    output logic                       cpu_wait,
    output logic                       busy
);

    localparam int unsigned NSEL     = 1 << DRV_W;
    localparam logic [3:0]  LAST_SEC = 4'(SECTORS - 1);

    typedef enum logic [1:0] {StIdle, StFlush, StLoad} state_e;
    typedef enum logic [1:0] {PhReq, PhRise, PhFall} phase_e;

    state_e               state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [3:0]           sec_q, sec_d;
    logic [31:0]          lba_q, lba_d;
    logic [DRIVES-1:0]    rd_q, rd_d, wr_q, wr_d, ack_q;
    logic [DRV_W-1:0]     cached_drive_q, cached_drive_d, pend_drive_q, pend_drive_d;
    logic [TRACK_W-1:0]   cached_track_q, cached_track_d, pend_track_q, pend_track_d;
    logic                 valid_q, valid_d, abort_q, abort_d;
    logic [SECTORS-1:0]   dirty_q, dirty_d, wr_set;
    logic [DRIVES-1:0]    mounted_q, mounted_d, ro_q, ro_d;

    // Padded copies so any drive_sel value indexes safely.
    logic [NSEL-1:0]         mounted_pad, ro_pad, mnt_pad, ack_pad, ack_q_pad, drv_onehot;
    logic [NSEL*TRACK_W-1:0] track_pad;
    logic [TRACK_W-1:0]      track_sel;
    logic [3:0]              low_sec;
    logic                    miss, ack_rise, ack_fall;
    logic                    unused_addr;

    assign unused_addr = ^fd_track_addr[8:0];

    always_comb begin
        mounted_pad = '0;
        mounted_pad[DRIVES-1:0] = mounted_q;
        ro_pad = '0;
        ro_pad[DRIVES-1:0] = ro_q;
        mnt_pad = '0;
        mnt_pad[DRIVES-1:0] = img_mounted;
        ack_pad = '0;
        ack_pad[DRIVES-1:0] = sd_ack;
        ack_q_pad = '0;
        ack_q_pad[DRIVES-1:0] = ack_q;
        track_pad = '0;
        track_pad[DRIVES*TRACK_W-1:0] = track;
        track_sel = track_pad[drive_sel*TRACK_W +: TRACK_W];
        drv_onehot = NSEL'(1) << cached_drive_q;
    end

    assign busy     = (state_q != StIdle);
    assign cpu_wait = busy;
    assign sd_lba   = lba_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;
    assign buf_sec  = busy ? sec_q : 4'd0;

    assign ack_rise = ack_pad[cached_drive_q] & ~ack_q_pad[cached_drive_q];
    assign ack_fall = ~ack_pad[cached_drive_q] & ack_q_pad[cached_drive_q];
    assign miss = (state_q == StIdle) && mounted_pad[drive_sel] &&
                  (!valid_q || (drive_sel != cached_drive_q) || (track_sel != cached_track_q));

    always_comb begin
        low_sec = 4'd0;
        for (int i = int'(SECTORS) - 1; i >= 0; i--) begin
            if (dirty_q[i]) low_sec = 4'(i);
        end
        wr_set = '0;
        if (fd_write_disk && valid_q && !ro_pad[cached_drive_q]) begin
            for (int i = 0; i < int'(SECTORS); i++) begin
                if (fd_track_addr[12:9] == 4'(i)) wr_set[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        sec_d          = sec_q;
        lba_d          = lba_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        cached_drive_d = cached_drive_q;
        cached_track_d = cached_track_q;
        pend_drive_d   = pend_drive_q;
        pend_track_d   = pend_track_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        mounted_d      = mounted_q;
        ro_d           = ro_q;
        abort_d        = abort_q;

        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    pend_drive_d = drive_sel;
                    pend_track_d = track_sel;
                    phase_d      = PhReq;
                    abort_d      = 1'b0;
                    if ((dirty_q != '0) && mounted_pad[cached_drive_q]) begin
                        state_d = StFlush;
                    end else begin
                        cached_drive_d = drive_sel;
                        cached_track_d = track_sel;
                        valid_d        = 1'b0;
                        dirty_d        = '0;
                        sec_d          = 4'd0;
                        state_d        = StLoad;
                    end
                end
            end
            default: begin
                unique case (phase_q)
                    PhReq: begin
                        if (abort_q) begin
                            state_d = StIdle;
                            abort_d = 1'b0;
                        end else begin
                            sec_d   = (state_q == StFlush) ? low_sec : sec_q;
                            lba_d   = 32'(cached_track_q) * 32'(SECTORS) + 32'(sec_d);
                            phase_d = PhRise;
                            if (state_q == StFlush) wr_d = drv_onehot[DRIVES-1:0];
                            else                    rd_d = drv_onehot[DRIVES-1:0];
                        end
                    end
                    PhRise: begin
                        if (ack_rise) begin
                            rd_d    = '0;
                            wr_d    = '0;
                            phase_d = PhFall;
                            if (state_q == StFlush) begin
                                for (int i = 0; i < int'(SECTORS); i++) begin
                                    if (sec_q == 4'(i)) dirty_d[i] = 1'b0;
                                end
                            end
                        end
                    end
                    PhFall: begin
                        if (ack_fall) begin
                            phase_d = PhReq;
                            if (abort_q) begin
                                state_d = StIdle;
                                abort_d = 1'b0;
                            end else if (state_q == StFlush) begin
                                if ((dirty_q | wr_set) == '0) begin
                                    cached_drive_d = pend_drive_q;
                                    cached_track_d = pend_track_q;
                                    valid_d        = 1'b0;
                                    sec_d          = 4'd0;
                                    state_d        = StLoad;
                                end
                            end else if (sec_q == LAST_SEC) begin
                                valid_d = 1'b1;
                                dirty_d = '0;
                                state_d = StIdle;
                            end else begin
                                sec_d = sec_q + 4'd1;
                            end
                        end
                    end
                    default: phase_d = PhReq;
                endcase
            end
        endcase

        // A write landing after the flush cleared its bit marks the sector dirty again.
        dirty_d = dirty_d | wr_set;

        for (int d = 0; d < int'(DRIVES); d++) begin
            if (img_mounted[d]) begin
                mounted_d[d] = img_size_nz;
                ro_d[d]      = img_readonly;
            end
        end
        // Remount of the cached drive mid-transfer: finish the handshake, drop the rest.
        if (busy && mnt_pad[cached_drive_q]) begin
            valid_d = 1'b0;
            dirty_d = '0;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= StIdle;
            phase_q        <= PhReq;
            sec_q          <= '0;
            lba_q          <= '0;
            rd_q           <= '0;
            wr_q           <= '0;
            ack_q          <= '0;
            cached_drive_q <= '0;
            cached_track_q <= '0;
            pend_drive_q   <= '0;
            pend_track_q   <= '0;
            valid_q        <= 1'b0;
            abort_q        <= 1'b0;
            dirty_q        <= '0;
            mounted_q      <= '0;
            ro_q           <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            sec_q          <= sec_d;
            lba_q          <= lba_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            ack_q          <= sd_ack;
            cached_drive_q <= cached_drive_d;
            cached_track_q <= cached_track_d;
            pend_drive_q   <= pend_drive_d;
            pend_track_q   <= pend_track_d;
            valid_q        <= valid_d;
            abort_q        <= abort_d;
            dirty_q        <= dirty_d;
            mounted_q      <= mounted_d;
            ro_q           <= ro_d;
        end
    end

endmodule

// File: tb/tb_fdd_track_cache.sv
// Directed bench for fdd_track_cache: a small HPS responder acks each request, a
// monitor logs every transfer, and logs are compared with hand-computed expectations.
module tb_fdd_track_cache;

    logic        clk_sys;
    logic        reset;
    logic [0:0]  drive_sel;
    logic [11:0] track;
    logic [1:0]  img_mounted;
    logic        img_size_nz, img_readonly, fd_write_disk;
    logic [12:0] fd_track_addr;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr, sd_ack;
    logic [3:0]  buf_sec;
    logic        cpu_wait, busy;

    fdd_track_cache #(.SECTORS(13), .DRIVES(2), .TRACK_W(6)) dut (
        .clk_sys(clk_sys), .reset(reset), .drive_sel(drive_sel), .track(track),
        .img_mounted(img_mounted), .img_size_nz(img_size_nz), .img_readonly(img_readonly),
        .fd_write_disk(fd_write_disk), .fd_track_addr(fd_track_addr), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .buf_sec(buf_sec),
        .cpu_wait(cpu_wait), .busy(busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {int wr; int drv; int lba; int sec; int wt;} xfer_t;
    typedef struct {
        string name; int mnt; int nz; int ro; int wmask; int dsel; int t0; int t1;
        int nwr; int wl0; int ws0; int wl1; int ws1; int wdrv; int nrd; int rl0; int rdrv;
    } vec_t;

    xfer_t      log_q[$];
    xfer_t      exp_q[$];
    vec_t       vecs[10];
    logic [1:0] prev_req;
    logic [1:0] hps_req;
    int         tests = 0;
    int         fails = 0;

    // Transfer monitor: one entry per request rising.
    always @(negedge clk_sys) begin
        if (((sd_rd | sd_wr) != 2'b00) && (prev_req == 2'b00)) begin
            log_q.push_back('{wr: int'(sd_wr != 2'b00), drv: int'(sd_rd[1] | sd_wr[1]),
                              lba: int'(sd_lba), sec: int'(buf_sec), wt: int'(cpu_wait)});
        end
        prev_req <= sd_rd | sd_wr;
    end

    // HPS responder.
    initial begin
        sd_ack = 2'b00;
        forever begin
            @(negedge clk_sys);
            hps_req = sd_rd | sd_wr;
            if ((hps_req != 2'b00) && !reset) begin
                repeat (2) @(negedge clk_sys);
                if ((sd_rd | sd_wr) == hps_req) begin
                    sd_ack = hps_req;
                    repeat (3) @(negedge clk_sys);
                    sd_ack = 2'b00;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic pulse_write(input int sec);
        fd_track_addr = {4'(sec), 9'h0a7};
        fd_write_disk = 1'b1;
        tick(1);
        fd_write_disk = 1'b0;
    endtask

    task automatic pulse_mount(input int m, input int nz, input int ro);
        img_mounted  = 2'(m);
        img_size_nz  = 1'(nz);
        img_readonly = 1'(ro);
        tick(1);
        img_mounted  = 2'b00;
    endtask

    task automatic add_wr(input int drv, input int lba, input int sec);
        exp_q.push_back('{wr: 1, drv: drv, lba: lba, sec: sec, wt: 1});
    endtask

    task automatic add_rd(input int drv, input int lba0, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{wr: 0, drv: drv, lba: lba0 + i, sec: i, wt: 1});
    endtask

    task automatic wait_sec(input string name, input int sec, input int want_wr);
        int cyc = 0;
        logic [1:0] r;
        logic hit = 1'b0;
        while (!hit && cyc < 3000) begin
            tick(1);
            cyc++;
            r = (want_wr != 0) ? sd_wr : sd_rd;
            hit = (r != 2'b00) && (int'(buf_sec) == sec);
        end
        check({name, ".reach"}, int'(hit), 1);
    endtask

    task automatic run_and_compare(input string name);
        int n = exp_q.size();
        int cyc = 0;
        if (n > 0) begin
            while ((log_q.size() < n || busy) && cyc < 3000) begin
                tick(1);
                cyc++;
            end
            check({name, ".done"}, int'(cyc < 3000), 1);
        end else begin
            tick(30);
        end
        check({name, ".count"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check($sformatf("%s[%0d].wr", name, i), log_q[i].wr, exp_q[i].wr);
            check($sformatf("%s[%0d].drv", name, i), log_q[i].drv, exp_q[i].drv);
            check($sformatf("%s[%0d].lba", name, i), log_q[i].lba, exp_q[i].lba);
            check($sformatf("%s[%0d].buf_sec", name, i), log_q[i].sec, exp_q[i].sec);
            check($sformatf("%s[%0d].cpu_wait", name, i), log_q[i].wt, exp_q[i].wt);
        end
        check({name, ".busy_end"}, int'(busy), 0);
        check({name, ".wait_end"}, int'(cpu_wait), 0);
        exp_q.delete();
        log_q.delete();
    endtask

    initial begin
        int wm;
        reset = 1'b1;
        drive_sel = 1'b0;
        track = {6'd0, 6'd3};
        img_mounted = 2'b00;
        img_size_nz = 1'b0;
        img_readonly = 1'b0;
        fd_write_disk = 1'b0;
        fd_track_addr = '0;

        //          name        mnt nz ro wmask     dsel t0 t1 nwr wl0 ws0 wl1 ws1 wdrv nrd rl0 rdrv
        vecs[0] = '{"load_t3",   1, 1, 0, 'h0000, 0, 3, 0, 0, 0,   0,  0,   0,  0,  13, 39, 0};
        vecs[1] = '{"wb_sec5",   0, 0, 0, 'h0020, 0, 4, 0, 1, 44,  5,  0,   0,  0,  13, 52, 0};
        vecs[2] = '{"mount_d1",  2, 1, 0, 'h0000, 0, 4, 0, 0, 0,   0,  0,   0,  0,  0,  0,  0};
        vecs[3] = '{"load_t7",   0, 0, 0, 'h0000, 0, 7, 0, 0, 0,   0,  0,   0,  0,  13, 91, 0};
        vecs[4] = '{"drive_sw",  0, 0, 0, 'h0402, 1, 7, 0, 2, 92,  1,  101, 10, 0,  13, 0,  1};
        vecs[5] = '{"ro_mount",  1, 1, 1, 'h0000, 0, 2, 0, 0, 0,   0,  0,   0,  0,  13, 26, 0};
        vecs[6] = '{"ro_write",  0, 0, 0, 'h0004, 0, 6, 0, 0, 0,   0,  0,   0,  0,  13, 78, 0};
        vecs[7] = '{"to_d1",     0, 0, 0, 'h0000, 1, 6, 0, 0, 0,   0,  0,   0,  0,  13, 0,  1};
        vecs[8] = '{"wb_d1",     1, 1, 0, 'h5000, 0, 6, 0, 1, 12,  12, 0,   0,  1,  13, 78, 0};
        vecs[9] = '{"unmnt_d1",  2, 0, 0, 'h0000, 1, 6, 0, 0, 0,   0,  0,   0,  0,  0,  0,  0};

        tick(3);
        check("rst.sd_lba", int'(sd_lba), 0);
        check("rst.sd_rd", int'(sd_rd), 0);
        check("rst.sd_wr", int'(sd_wr), 0);
        check("rst.buf_sec", int'(buf_sec), 0);
        check("rst.cpu_wait", int'(cpu_wait), 0);
        check("rst.busy", int'(busy), 0);
        reset = 1'b0;
        tick(5);
        check("unmounted.busy", int'(busy), 0);

        for (int v = 0; v < 10; v++) begin
            log_q.delete();
            exp_q.delete();
            wm = vecs[v].wmask;
            for (int s = 0; s < 16; s++) if (wm[s]) pulse_write(s);
            if (vecs[v].mnt != 0) pulse_mount(vecs[v].mnt, vecs[v].nz, vecs[v].ro);
            drive_sel = 1'(vecs[v].dsel);
            track = {6'(vecs[v].t1), 6'(vecs[v].t0)};
            if (vecs[v].nwr > 0) add_wr(vecs[v].wdrv, vecs[v].wl0, vecs[v].ws0);
            if (vecs[v].nwr > 1) add_wr(vecs[v].wdrv, vecs[v].wl1, vecs[v].ws1);
            add_rd(vecs[v].rdrv, vecs[v].rl0, vecs[v].nrd);
            run_and_compare(vecs[v].name);
        end

        // Track change during sector 6 of a load: load finishes, then the new track loads.
        drive_sel = 1'b0;
        track = {6'd0, 6'd3};
        wait_sec("midload", 6, 0);
        track = {6'd0, 6'd5};
        add_rd(0, 39, 13);
        add_rd(0, 65, 13);
        run_and_compare("midload");

        // Remount of the cached drive during sector 3: handshake completes, load restarts.
        track = {6'd0, 6'd1};
        wait_sec("abort", 3, 0);
        pulse_mount(1, 1, 0);
        add_rd(0, 13, 4);
        add_rd(0, 13, 13);
        run_and_compare("abort");

        // Write to the sector being flushed while its ack is high: flushed twice.
        pulse_write(2);
        track = {6'd0, 6'd2};
        wait_sec("reflush", 2, 1);
        begin
            int cyc = 0;
            while (sd_ack == 2'b00 && cyc < 100) begin
                tick(1);
                cyc++;
            end
            check("reflush.ack", int'(sd_ack != 2'b00), 1);
        end
        tick(1);
        pulse_write(2);
        add_wr(0, 15, 2);
        add_wr(0, 15, 2);
        add_rd(0, 26, 13);
        run_and_compare("reflush");

        // Reset while a write-back request is up.
        pulse_write(0);
        track = {6'd0, 6'd4};
        wait_sec("rstflush", 0, 1);
        check("rstflush.sd_wr_before", int'(sd_wr), 1);
        reset = 1'b1;
        tick(1);
        check("rstflush.sd_wr", int'(sd_wr), 0);
        check("rstflush.cpu_wait", int'(cpu_wait), 0);
        check("rstflush.busy", int'(busy), 0);
        check("rstflush.sd_lba", int'(sd_lba), 0);
        reset = 1'b0;
        tick(2);
        log_q.delete();
        exp_q.delete();
        pulse_mount(1, 1, 0);
        add_rd(0, 52, 13);
        run_and_compare("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
